// File: rtl/vga_pixel_fetch.sv
// Pixel fetch stage between a frame-memory read FIFO and the VGA timing generator.
// Streams one FIFO word per requested pixel and falls back to BG_COLOR when idle or starved.
module vga_pixel_fetch #(
  parameter logic [10:0] H_DISP   = 11'd1024,
  parameter logic [10:0] V_DISP   = 11'd768,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  output logic [15:0] pixel_data,
  output logic        fifo_rd_en,
  input  logic [15:0] fifo_rd_data,
  input  logic        fifo_empty,
  input  logic        fetch_en,
  output logic        frame_sync,
  input  logic        cnt_clr,
  output logic [15:0] underflow_cnt
);

  typedef enum logic [1:0] {StIdle, StStream, StStarved} state_e;

  state_e      state_q, state_d;
  logic        src_q;
  logic        frame_sync_q;
  logic [15:0] cnt_q, cnt_d;
  logic        req;
  logic        last_req;
  logic        underflow;

  always_comb begin
    req       = (pixel_xpos != 11'd0) && (pixel_xpos <= H_DISP) &&
                (pixel_ypos != 11'd0) && (pixel_ypos <= V_DISP);
    last_req  = req && (pixel_xpos == H_DISP) && (pixel_ypos == V_DISP);
    underflow = (state_q == StStream) && req && fifo_empty;

    state_d = state_q;
    // Frame end overrides starvation so an underflow on the last pixel cannot stick.
    if (last_req) begin
      state_d = fetch_en ? StStream : StIdle;
    end else if (underflow) begin
      state_d = StStarved;
    end

    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = {15'd0, underflow};
    end else if (underflow && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= StIdle;
      src_q        <= 1'b0;
      frame_sync_q <= 1'b0;
      cnt_q        <= 16'd0;
    end else begin
      state_q      <= state_d;
      src_q        <= fifo_rd_en;
      frame_sync_q <= last_req;
      cnt_q        <= cnt_d;
    end
  end

  assign fifo_rd_en    = (state_q == StStream) && req && !fifo_empty;
  assign pixel_data    = src_q ? fifo_rd_data : BG_COLOR;
  assign frame_sync    = frame_sync_q;
  assign underflow_cnt = cnt_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Randomized scoreboard bench for vga_pixel_fetch on a small frame, plus a 1x1-frame
// instance that drives the underflow counter into saturation.
module tb_vga_pixel_fetch;

  localparam logic [10:0] H  = 11'd12;
  localparam logic [10:0] V  = 11'd6;
  localparam logic [15:0] BG = 16'h07E0;
  localparam logic [15:0] SBG = 16'hF81F;

  logic        vga_clk = 1'b0;
  logic        sys_rst;
  logic [10:0] pixel_xpos, pixel_ypos;
  logic [15:0] pixel_data;
  logic        fifo_rd_en;
  logic [15:0] fifo_rd_data;
  logic        fifo_empty, fetch_en, frame_sync, cnt_clr;
  logic [15:0] underflow_cnt;

  logic        s_rst, s_rd_en, s_fsync, s_clr;
  logic [15:0] s_pix, s_cnt;

  always #5 vga_clk = ~vga_clk;

  vga_pixel_fetch #(.H_DISP(H), .V_DISP(V), .BG_COLOR(BG)) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .pixel_data(pixel_data), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .fetch_en(fetch_en), .frame_sync(frame_sync),
    .cnt_clr(cnt_clr), .underflow_cnt(underflow_cnt)
  );

  vga_pixel_fetch #(.H_DISP(11'd1), .V_DISP(11'd1), .BG_COLOR(SBG)) sat (
    .vga_clk(vga_clk), .sys_rst(s_rst), .pixel_xpos(11'd1), .pixel_ypos(11'd1),
    .pixel_data(s_pix), .fifo_rd_en(s_rd_en), .fifo_rd_data(16'hDEAD),
    .fifo_empty(1'b1), .fetch_en(1'b1), .frame_sync(s_fsync),
    .cnt_clr(s_clr), .underflow_cnt(s_cnt)
  );

  typedef struct {
    logic [15:0] pix;
    logic        fs;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic        in_reset;
  logic        sat_done = 1'b0;
  logic [15:0] salt;
  int unsigned rd_ptr = 0;

  // Reference model: per-frame streaming decision, starvation flag, words consumed, counter.
  bit          m_stream, m_starved;
  int unsigned m_idx;
  int unsigned m_cnt;
  logic        cur_fe;

  function automatic logic [15:0] word_of(input int unsigned i);
    int unsigned v;
    v = i * 32'd40503 + 32'd977;
    return v[15:0] ^ salt;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Upstream FIFO: standard (non show-ahead) read, word valid the cycle after the strobe.
  always @(posedge vga_clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= word_of(rd_ptr);
      rd_ptr       <= rd_ptr + 1;
    end
  end

  always @(posedge vga_clk) begin
    #2;
    if (in_reset) begin
      check("rst_pixel", pixel_data, BG);
      check("rst_fsync", {15'd0, frame_sync}, 16'd0);
      check("rst_cnt", underflow_cnt, 16'd0);
    end else if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("pixel_data", pixel_data, mon_e.pix);
      check("frame_sync", {15'd0, frame_sync}, {15'd0, mon_e.fs});
      check("underflow_cnt", underflow_cnt, mon_e.cnt);
    end
  end

  task automatic drive_cycle(input logic [10:0] x, input logic [10:0] y, input logic empty,
                             input logic clr);
    bit   req, last, rd, under;
    exp_t e;
    @(negedge vga_clk);
    pixel_xpos = x;
    pixel_ypos = y;
    fifo_empty = empty;
    fetch_en   = cur_fe;
    cnt_clr    = clr;
    req   = (x >= 1) && (x <= H) && (y >= 1) && (y <= V);
    last  = req && (x == H) && (y == V);
    rd    = m_stream && !m_starved && req && !empty;
    under = m_stream && !m_starved && req && empty;
    #1;
    check("fifo_rd_en", {15'd0, fifo_rd_en}, {15'd0, rd});
    if (clr) m_cnt = under ? 1 : 0;
    else if (under && m_cnt < 65535) m_cnt++;
    e.pix = rd ? word_of(m_idx) : BG;
    e.fs  = last;
    e.cnt = m_cnt[15:0];
    exp_q.push_back(e);
    if (rd) m_idx++;
    if (under) m_starved = 1;
    if (last) begin
      m_stream  = cur_fe;
      m_starved = 0;
    end
  endtask

  task automatic do_reset(input logic [10:0] x, input logic [10:0] y);
    @(negedge vga_clk);
    pixel_xpos = x;
    pixel_ypos = y;
    fifo_empty = 1'b0;
    sys_rst    = 1'b1;
    in_reset   = 1'b1;
    exp_q.delete();
    #1;
    check("rst_rd_en_now", {15'd0, fifo_rd_en}, 16'd0);
    check("rst_pixel_now", pixel_data, BG);
    repeat (2) @(negedge vga_clk);
    sys_rst   = 1'b0;
    in_reset  = 1'b0;
    m_stream  = 0;
    m_starved = 0;
    m_cnt     = 0;
  endtask

  // Lines are separated by blanking cycles; frames run back to back.
  task automatic run_frame(input int ue_x, input int ue_y, input int empty_pct,
                           input int fx, input int fy, input logic fnew,
                           input int clr_pct, input int rx, input int ry);
    logic e, c;
    for (int y = 1; y <= int'(V); y++) begin
      if (y > 1) begin
        drive_cycle(11'd0, 11'(y), 1'b0, 1'b0);
        drive_cycle(H + 11'd1, 11'(y), 1'b0, 1'b0);
        drive_cycle(11'd1, V + 11'd1, 1'b1, 1'b0);
      end
      for (int x = 1; x <= int'(H); x++) begin
        if (x == rx && y == ry) begin
          do_reset(11'(x), 11'(y));
          return;
        end
        if (x == fx && y == fy) cur_fe = fnew;
        e = ((x == ue_x) && (y == ue_y)) || ($urandom_range(99) < empty_pct);
        c = ($urandom_range(99) < clr_pct);
        drive_cycle(11'(x), 11'(y), e, c);
      end
    end
  endtask

  initial begin
    int guard;
    salt         = 16'($urandom);
    fifo_rd_data = 16'h0000;
    sys_rst      = 1'b1;
    in_reset     = 1'b1;
    pixel_xpos   = 11'd0;
    pixel_ypos   = 11'd0;
    fifo_empty   = 1'b0;
    cnt_clr      = 1'b0;
    cur_fe       = 1'b1;
    fetch_en     = 1'b1;
    m_stream     = 0;
    m_starved    = 0;
    m_idx        = 0;
    m_cnt        = 0;
    repeat (3) @(negedge vga_clk);
    #1;
    check("reset_rd_en", {15'd0, fifo_rd_en}, 16'd0);
    sys_rst  = 1'b0;
    in_reset = 1'b0;

    run_frame(0, 0, 0, 0, 0, 1'b1, 0, 0, 0);    // first frame after reset: idle
    run_frame(0, 0, 0, 0, 0, 1'b1, 0, 0, 0);    // streams
    run_frame(5, 3, 0, 0, 0, 1'b1, 0, 0, 0);    // mid-frame underflow
    run_frame(0, 0, 0, 0, 0, 1'b1, 0, 0, 0);
    run_frame(12, 6, 0, 0, 0, 1'b1, 0, 0, 0);   // underflow on last request
    run_frame(0, 0, 0, 0, 0, 1'b1, 0, 0, 0);
    run_frame(0, 0, 0, 6, 4, 1'b0, 0, 0, 0);    // fetch_en dropped mid-frame
    run_frame(0, 0, 0, 6, 4, 1'b1, 0, 0, 0);    // idle frame, fetch_en raised mid-frame
    run_frame(0, 0, 0, 0, 0, 1'b1, 0, 0, 0);
    run_frame(0, 0, 0, 0, 0, 1'b1, 0, 5, 3);    // reset mid-frame
    run_frame(0, 0, 0, 0, 0, 1'b1, 0, 0, 0);
    run_frame(0, 0, 0, 0, 0, 1'b1, 0, 0, 0);
    for (int f = 0; f < 30; f++) begin
      run_frame(0, 0, $urandom_range(4), $urandom_range(1, 12), $urandom_range(1, 6),
                ($urandom_range(3) != 0), 4, 0, 0);
    end
    drive_cycle(11'd0, 11'd0, 1'b0, 1'b0);
    repeat (2) @(negedge vga_clk);
    check("read_count", rd_ptr[15:0], m_idx[15:0]);

    guard = 0;
    while (!sat_done && guard < 100000) begin
      @(posedge vga_clk);
      guard++;
    end
    if (!sat_done) begin
      checks++;
      errors++;
      $display("FAIL sat_timeout: got not-done expected done");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // 1x1 frame: every cycle is a last request, so each cycle in STREAM with an empty FIFO
  // is a counted underflow.
  initial begin
    s_rst = 1'b1;
    s_clr = 1'b0;
    repeat (2) @(negedge vga_clk);
    s_rst = 1'b0;
    repeat (100) @(posedge vga_clk);
    #2;
    check("sat_cnt_99", s_cnt, 16'd99);
    check("sat_rd_en", {15'd0, s_rd_en}, 16'd0);
    check("sat_pixel", s_pix, SBG);
    check("sat_fsync", {15'd0, s_fsync}, 16'd1);
    repeat (65436) @(posedge vga_clk);
    #2;
    check("sat_cnt_max", s_cnt, 16'hFFFF);
    repeat (3) @(posedge vga_clk);
    #2;
    check("sat_cnt_hold", s_cnt, 16'hFFFF);
    @(negedge vga_clk);
    s_clr = 1'b1;
    @(posedge vga_clk);
    #2;
    check("sat_clr_underflow", s_cnt, 16'd1);
    @(negedge vga_clk);
    s_clr = 1'b0;
    @(posedge vga_clk);
    #2;
    check("sat_after_clr", s_cnt, 16'd2);
    sat_done = 1'b1;
  end

endmodule

// File: doc/vga_pixel_fetch.md
VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 SHALL have parameter H_DISP, default 11'd1024: active pixels per line.
REQ-002 SHALL have parameter V_DISP, default 11'd768: active lines per frame.
REQ-003 SHALL have parameter BG_COLOR, default 16'h0000: RGB565 fill value for pixels not sourced from the FIFO.
REQ-004 SHALL have port vga_clk, input, 1: pixel clock; all logic on its rising edge.
REQ-005 SHALL have port sys_rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port pixel_xpos, input, 11: requested column; 0 = no request; 1..H_DISP = valid.
REQ-007 SHALL have port pixel_ypos, input, 11: requested line, 1..V_DISP.
REQ-008 SHALL have port pixel_data, output, 16: RGB565 pixel returned one cycle after the request.
REQ-009 SHALL have port fifo_rd_en, output, 1: read strobe to the frame-memory read FIFO.
REQ-010 SHALL have port fifo_rd_data, input, 16: FIFO word, valid the cycle after fifo_rd_en (standard, not show-ahead).
REQ-011 SHALL have port fifo_empty, input, 1: FIFO has no word available this cycle.
REQ-012 SHALL have port fetch_en, input, 1: enable FIFO streaming; sampled only at frame end.
REQ-013 SHALL have port frame_sync, output, 1: one-cycle pulse telling the upstream writer to flush and restart the frame.
REQ-014 SHALL have port cnt_clr, input, 1: synchronous clear of underflow_cnt.
REQ-015 SHALL have port underflow_cnt, output, 16: saturating count of starved pixels.

Function
REQ-016 A request SHALL be a cycle with 1 <= pixel_xpos <= H_DISP and 1 <= pixel_ypos <= V_DISP; any other coordinate is no request.
REQ-017 The last request SHALL be pixel_xpos == H_DISP and pixel_ypos == V_DISP.
REQ-018 The FSM SHALL have three states: IDLE, STREAM and STARVED.
REQ-019 fifo_rd_en SHALL be combinational and asserted only when state == STREAM and there is a request and !fifo_empty.
REQ-020 A registered flag src_q SHALL capture fifo_rd_en each cycle; pixel_data = src_q ? fifo_rd_data : BG_COLOR, giving 1-cycle request-to-data latency.
REQ-021 In IDLE: no reads; pixel_data = BG_COLOR.
REQ-022 In STREAM: one read per request.
REQ-023 In STREAM, a request with fifo_empty = 1 is an underflow: no read, BG_COLOR output for that pixel, underflow_cnt increments, next state STARVED.
REQ-024 In STARVED: no reads; BG_COLOR output for the rest of the frame, so no pixel misalignment can persist; underflow_cnt does not increment.
REQ-025 In any state, the cycle after the last request SHALL have frame_sync = 1 for exactly one cycle.
REQ-026 At that same edge, the next state SHALL be STREAM if fetch_en = 1, else IDLE.
REQ-027 An underflow on the last request itself SHALL be counted, frame_sync SHALL still pulse, and the next state follows fetch_en (not STARVED).
REQ-028 fetch_en changes mid-frame SHALL have no effect until the next frame end.
REQ-029 underflow_cnt SHALL saturate at 16'hFFFF.
REQ-030 cnt_clr SHALL take priority over hold; cnt_clr together with an underflow in the same cycle SHALL yield underflow_cnt = 1.
REQ-031 Requests while frame_sync is high SHALL be handled normally; the state update at frame end takes effect first.

Reset
REQ-032 While sys_rst = 1 (asynchronous assert, synchronous to vga_clk on release), outputs SHALL be: state IDLE, src_q 0, pixel_data = BG_COLOR, fifo_rd_en 0, frame_sync 0, underflow_cnt 0.
REQ-033 After reset the block SHALL stream no FIFO data until the first frame end, so the first streamed frame starts aligned with frame_sync.
REQ-034 Reset asserted mid-frame SHALL abandon the frame immediately with no further reads.

Verification
REQ-035 Reset, then fetch_en = 1, FIFO never empty, two full 1024x768 frames -> frame 1 is all BG_COLOR with 0 reads; frame_sync pulses after each last request; frame 2 has 786432 reads and each pixel_data equals the FIFO word read one cycle earlier.
REQ-036 In STREAM, fifo_empty = 1 at request (x=100, y=5) -> fifo_rd_en = 0 there and for all later requests in the frame; BG_COLOR from that pixel on; underflow_cnt = 1; STREAM resumes after frame_sync.
REQ-037 fifo_empty = 1 only at the last request (1024, 768) -> underflow_cnt = 1; frame_sync pulses; next frame streams normally.
REQ-038 fetch_en dropped at (500, 300) -> reads continue to frame end, then IDLE with all-BG next frame; raised again -> streaming resumes only after the following frame_sync.
REQ-039 underflow_cnt preloaded to 16'hFFFF by repeated starved frames, one more underflow -> stays 16'hFFFF; cnt_clr and an underflow in the same cycle -> 1.
REQ-040 sys_rst pulsed at (10, 10) mid-frame -> fifo_rd_en drops the same cycle; pixel_data = BG_COLOR; no reads until the frame end after reset release.
